sevenseg_capture: RTL and testbench

- Receive-side counterpart of the nibble-to-seven-segment encoder.
- Watches a multiplexed seven-segment bus (segment pattern plus one-hot digit strobe), debounces each digit, and decodes each pattern back to a 4-bit nibble.
- Assembles a full frame into one word and presents it on a valid/ready handshake.
- Used for on-board self-check of the display path and for readback of displayed hash fragments.

---
 rtl/sevenseg_capture.sv | 174 +++++++++++++++++
 tb/tb_sevenseg_capture.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture.sv
// ============================================================================
// Module      : sevenseg_capture
// Description : Receive-side seven-segment bus capture. Watches a multiplexed
//               seven-segment bus (active-low pattern + one-hot digit
//               strobe), waits for each digit to be stable, decodes the
//               glyph back to a nibble and assembles a full frame that is
//               offered on a valid/ready handshake.
// Ports       : clk_i        - system clock, rising edge
//               reset_i      - synchronous active-high reset
//               seg_i        - segment pattern [6:0] = g f e d c b a
//               digit_sel_i  - one-hot digit strobe
//               word_o       - decoded frame, digit i in [4i+3:4i]
//               error_o      - digit i glyph was not a legal hex glyph
//               valid_o      - frame available
//               ready_i      - consumer accepts frame when valid_o & ready_i
// Options     : SEVENSEG_CAPTURE_ACTIVE_HIGH_EN - treat seg_i as active-high
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   digit_sel_i,
    output logic [4*NUM_DIGITS-1:0] word_o,
    output logic [NUM_DIGITS-1:0]   error_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    // Counter must hold STABLE_CYCLES+1 (up to 256).
    localparam int             CNT_W   = 9;
    localparam logic [CNT_W-1:0] CNT_STB = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES + 1);
    localparam int             KEY_W   = 7 + NUM_DIGITS;

    typedef enum logic [0:0] {
        ST_CAPTURE = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    // Pattern normalised to active-low so one decode table serves both builds.
    logic [6:0] seg_norm;
`ifdef SEVENSEG_CAPTURE_ACTIVE_HIGH_EN
    assign seg_norm = ~seg_i;
`else
    assign seg_norm = seg_i;
`endif

    logic [KEY_W-1:0]        key;
    logic [KEY_W-1:0]        prev_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sample_evt;
    logic                    sel_onehot;
    logic [3:0]              dec_nib;
    logic                    dec_err;
    state_t                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] word_q, word_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;

    assign key = {seg_norm, digit_sel_i};

    // Run-length of identical bus values; saturating one above the threshold
    // guarantees the sample event fires exactly once per stable run.
    always_comb begin
        cnt_d = cnt_q;
        if (key != prev_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign sample_evt = (cnt_d == CNT_STB);

    // Exactly one strobe bit set: non-zero and clearing the lowest set bit
    // leaves nothing.
    assign sel_onehot = (digit_sel_i != '0) &&
                        ((digit_sel_i & (digit_sel_i - NUM_DIGITS'(1))) == '0);

    // Glyph decode (active-low, g f e d c b a).
    always_comb begin
        dec_nib = 4'h0;
        dec_err = 1'b0;
        case (seg_norm)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0010000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_err = 1'b1;
            end
        endcase
    end

    // Frame assembly FSM.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        word_d  = word_q;
        err_d   = err_q;
        case (state_q)
            ST_CAPTURE: begin
                if (sample_evt && sel_onehot) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (digit_sel_i[i]) begin
                            word_d[4*i +: 4] = dec_nib;
                            err_d[i]         = dec_err;
                            mask_d[i]        = 1'b1;
                        end
                    end
                    if (mask_d == {NUM_DIGITS{1'b1}}) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // valid_o is high throughout HOLD, so ready_i alone completes
                // the handshake; any concurrent sample is dropped.
                if (ready_i) begin
                    state_d = ST_CAPTURE;
                    mask_d  = '0;
                end
            end
            default: begin
                state_d = ST_CAPTURE;
                mask_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_CAPTURE;
            mask_q  <= '0;
            word_q  <= '0;
            err_q   <= '0;
        end else begin
            prev_q  <= key;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            mask_q  <= mask_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    assign word_o  = word_q;
    assign error_o = err_q;
    assign valid_o = (state_q == ST_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
// ============================================================================
// Module      : tb_sevenseg_capture
// Description : Self-checking bench for sevenseg_capture. A reference model
//               built from glyph lookup, per-digit arrays and run lengths
//               predicts each frame; predicted frames go into a queue that a
//               negedge monitor pops whenever the DUT raises valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sevenseg_capture;

    localparam int N = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [6:0]    seg_i;
    logic [N-1:0]  digit_sel_i;
    logic [4*N-1:0] word_o;
    logic [N-1:0]  error_o;
    logic          valid_o;
    logic          ready_i;

    always #5 clk = ~clk;

    sevenseg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .seg_i       (seg_i),
        .digit_sel_i (digit_sel_i),
        .word_o      (word_o),
        .error_o     (error_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    // Legal glyphs; index is the nibble value.
    logic [6:0] glyph [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [4*N-1:0] w;
        logic [N-1:0]   e;
        int             edge_at;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int frames_seen = 0;
    bit started = 0;

    // Reference model state.
    logic [3:0]  m_word [N];
    logic        m_err  [N];
    bit          m_mask [N];
    bit          m_hold;
    logic [10:0] m_prev;
    int          m_run;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, edge_n);
        end
    endfunction

    function automatic void decode(input logic [6:0] s, output logic [3:0] n,
                                   output logic e);
        n = 4'h0;
        e = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (glyph[k] == s) begin
                n = 4'(k);
                e = 1'b0;
            end
        end
    endfunction

    function automatic logic [4*N-1:0] pack_word();
        logic [4*N-1:0] w;
        for (int k = 0; k < N; k++) w[4*k +: 4] = m_word[k];
        return w;
    endfunction

    function automatic logic [N-1:0] pack_err();
        logic [N-1:0] e;
        for (int k = 0; k < N; k++) e[k] = m_err[k];
        return e;
    endfunction

    // Effect of one clock edge on the model.
    function automatic void model_edge(input logic [6:0] s, input logic [N-1:0] sel,
                                       input logic rdy, input logic rst);
        logic [10:0] v;
        logic [3:0]  nib;
        logic        er;
        bit          full;
        exp_t        ex;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_word[k] = 4'h0;
                m_err[k]  = 1'b0;
                m_mask[k] = 0;
            end
            m_hold = 0;
            m_prev = '0;
            m_run  = 0;
            return;
        end
        v = {s, sel};
        if (v == m_prev) begin
            if (m_run < S + 1) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = v;
        if (m_hold) begin
            if (rdy) begin
                m_hold = 0;
                for (int k = 0; k < N; k++) m_mask[k] = 0;
            end
        end else if (m_run == S && $countones(sel) == 1) begin
            decode(s, nib, er);
            for (int k = 0; k < N; k++) begin
                if (sel[k]) begin
                    m_word[k] = nib;
                    m_err[k]  = er;
                    m_mask[k] = 1;
                end
            end
            full = 1;
            for (int k = 0; k < N; k++) if (!m_mask[k]) full = 0;
            if (full) begin
                m_hold     = 1;
                ex.w       = pack_word();
                ex.e       = pack_err();
                ex.edge_at = edge_n;
                exp_q.push_back(ex);
            end
        end
    endfunction

    task automatic step(input logic [6:0] s, input logic [N-1:0] sel,
                        input logic rdy, input logic rst);
        seg_i       = s;
        digit_sel_i = sel;
        ready_i     = rdy;
        reset_i     = rst;
        @(posedge clk);
        edge_n++;
        if (rst) started = 1;
        model_edge(s, sel, rdy, rst);
        #1;
    endtask

    task automatic hold_digit(input int d, input logic [6:0] s, input int n);
        for (int c = 0; c < n; c++) step(s, N'(1) << d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int c = 0; c < n; c++) step(7'h7F, '0, rdy, 1'b0);
    endtask

    // Monitor: per-cycle output tracking plus scoreboard pop on valid rise.
    logic prev_valid = 1'b0;
    exp_t got;
    always @(negedge clk) begin
        if (started) begin
            check("valid", 32'(valid_o), 32'(m_hold));
            check("word", 32'(word_o), 32'(pack_word()));
            check("error", 32'(error_o), 32'(pack_err()));
            if (valid_o && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(1), 32'(0));
                end else begin
                    got = exp_q.pop_front();
                    frames_seen++;
                    check("frame_word", 32'(word_o), 32'(got.w));
                    check("frame_error", 32'(error_o), 32'(got.e));
                    check("frame_latency_edge", 32'(edge_n), 32'(got.edge_at));
                end
            end
            prev_valid = valid_o;
        end
    end

    initial begin
        // Reset state.
        step(7'h7F, '0, 1'b0, 1'b1);
        step(7'h7F, '0, 1'b0, 1'b1);
        #4;
        check("reset_valid", 32'(valid_o), 32'(0));
        check("reset_word", 32'(word_o), 32'(0));
        check("reset_error", 32'(error_o), 32'(0));

        // Frame F427, then hold for 20 cycles without ready.
        hold_digit(0, 7'b1111000, 6);
        hold_digit(1, 7'b0100100, 6);
        hold_digit(2, 7'b0011001, 6);
        hold_digit(3, 7'b0001110, 6);
        #4;
        check("tp1_word", 32'(word_o), 32'h0000F427);
        check("tp1_valid", 32'(valid_o), 32'(1));
        for (int c = 0; c < 20; c++) step(glyph[c % 16], N'(1) << (c % N), 1'b0, 1'b0);
        #4;
        check("tp1_hold_word", 32'(word_o), 32'h0000F427);

        // Accept, then 8888.
        idle(1, 1'b1);
        #4;
        check("tp2_valid_drop", 32'(valid_o), 32'(0));
        for (int d = 0; d < N; d++) hold_digit(d, 7'b0000000, 6);
        #4;
        check("tp2_word", 32'(word_o), 32'h00008888);

        // Blank digit 2.
        idle(1, 1'b1);
        hold_digit(0, 7'b1000000, 6);
        hold_digit(1, 7'b1000000, 6);
        hold_digit(2, 7'b1111111, 6);
        hold_digit(3, 7'b1000000, 6);
        #4;
        check("tp3_word", 32'(word_o), 32'h00000000);
        check("tp3_error", 32'(error_o), 32'b0100);
        check("tp3_valid", 32'(valid_o), 32'(1));

        // Digit 0 toggling faster than the stability window.
        idle(1, 1'b1);
        for (int t = 0; t < 10; t++) hold_digit(0, (t % 2) ? 7'b1111001 : 7'b1000000, 3);
        step(7'b1111111, 4'b0011, 1'b0, 1'b0);
        for (int c = 0; c < 9; c++) step(7'b1111111, 4'b0011, 1'b0, 1'b0);
        idle(10, 1'b0);
        hold_digit(1, 7'b0110000, 6);
        hold_digit(1, 7'b0010000, 6);
        hold_digit(2, 7'b1111001, 6);
        hold_digit(3, 7'b1111001, 6);
        #4;
        check("tp4_no_frame_without_d0", 32'(valid_o), 32'(0));
        hold_digit(0, 7'b1111001, 6);
        #4;
        check("tp4_digit1_resample", 32'(word_o[7:4]), 32'h9);

        // Reset mid-frame.
        idle(1, 1'b1);
        hold_digit(0, 7'b0001000, 6);
        hold_digit(1, 7'b0001000, 6);
        hold_digit(2, 7'b0001000, 6);
        step(7'h7F, '0, 1'b0, 1'b1);
        #4;
        check("tp5_reset_word", 32'(word_o), 32'(0));
        hold_digit(3, 7'b0000011, 6);
        #4;
        check("tp5_partial_after_reset", 32'(valid_o), 32'(0));
        hold_digit(0, 7'b0000011, 6);
        hold_digit(1, 7'b0000011, 6);
        hold_digit(2, 7'b0000011, 6);
        #4;
        check("tp5_word", 32'(word_o), 32'h0000BBBB);

        // Randomized traffic.
        for (int sgm = 0; sgm < 400; sgm++) begin
            logic [6:0]   s;
            logic [N-1:0] sel;
            int           r, len;
            r = $urandom_range(0, 9);
            if (r < 8)       sel = N'(1) << (r % N);
            else if (r == 8) sel = '0;
            else             sel = N'($urandom_range(3, 15)) | N'(4'b0011);
            s   = ($urandom_range(0, 5) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++)
                step(s, sel, ($urandom_range(0, 5) == 0), 1'b0);
            if ($urandom_range(0, 59) == 0) step(7'h7F, '0, 1'b0, 1'b1);
        end
        idle(2, 1'b0);
        #4;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        check("frames_seen_min", 32'(frames_seen >= 6), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
